// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage controller.
//   mem_state_e     : controller FSM states
//   memwb_t         : MEM/WB register contents
//   ACK_TIMEOUT_DEF : default ack wait limit (0 = wait forever)
//   READ_ERR_VAL_DEF: default data returned by a timed-out access
//   cnt_w()         : wait-counter width for a given timeout
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int unsigned ACK_TIMEOUT_DEF  = 255;
  localparam logic [31:0] READ_ERR_VAL_DEF = 32'hDEADBEEF;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  reg_dst;
  } memwb_t;

  // Width of the wait counter. A disabled timeout still needs a
  // one-bit counter so the vector is legal.
  function automatic int unsigned cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst_n : clock, synchronous active-low reset
//   bubble_i   : load all-zero (no writeback) instead of d_i
//   d_i        : fields selected by the MEM-stage controller
//   q_o        : registered MEM/WB fields
import mem_pkg::*;

module mem_wb_reg (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble_i,
  input  memwb_t d_i,
  output memwb_t q_o
);

  memwb_t q_q;

  always_ff @(posedge clk) begin
    if (!rst_n)        q_q <= '0;
    else if (bubble_i) q_q <= '0;
    else               q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller between EX/MEM and writeback.
//   EX/MEM inputs : wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite,
//                   AluResult (byte address), MuxForwardB (store data), MuxRegDst
//   Data memory   : dmem_req/we/addr/wdata (registered), dmem_rdata, dmem_ack
//   Hazard        : mem_stall (combinational) freezes PC..EX/MEM
//   mem_err       : one-cycle pulse when an access times out
//   MEM/WB outputs: wb_RegWrite_out, wb_MemToReg_out, ReadData_out,
//                   AluResult_out, MuxRegDst_out
import mem_pkg::*;

module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter logic [31:0] READ_ERR_VAL = READ_ERR_VAL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_RegWrite,
  input  logic        wb_MemToReg,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [31:0] AluResult,
  input  logic [31:0] MuxForwardB,
  input  logic [4:0]  MuxRegDst,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        wb_RegWrite_out,
  output logic        wb_MemToReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] AluResult_out,
  output logic [4:0]  MuxRegDst_out
);

  localparam int unsigned CW = cnt_w(ACK_TIMEOUT);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        rw_q, rw_d, m2r_q, m2r_d;
  logic [4:0]  dst_q, dst_d;

  logic        stall, wb_bubble, timeout_hit;
  logic [CW:0] cnt_nxt;
  memwb_t      wb_d, wb_q;

  // One extra bit so the compare against ACK_TIMEOUT cannot wrap.
  assign cnt_nxt     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_nxt == (CW+1)'(ACK_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    rw_d      = rw_q;
    m2r_d     = m2r_q;
    dst_d     = dst_q;
    stall     = 1'b0;
    wb_bubble = 1'b1;
    wb_d      = '0;
    case (state_q)
      IDLE: begin
        if (mem_MemRead || mem_MemWrite) begin
          // Read+write together is issued as a write.
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_MemWrite;
          addr_d  = AluResult;
          wdata_d = MuxForwardB;
          rw_d    = wb_RegWrite;
          m2r_d   = wb_MemToReg;
          dst_d   = MuxRegDst;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          wb_bubble = 1'b0;
          wb_d      = '{wb_RegWrite, wb_MemToReg, 32'h0, AluResult, MuxRegDst};
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_nxt[CW-1:0];
        if (dmem_ack) begin
          rdata_d = we_q ? 32'h0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = READ_ERR_VAL;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // EX/MEM advances on this edge, so the op is not seen again.
        wb_bubble = 1'b0;
        wb_d      = '{rw_q, m2r_q, rdata_q, addr_q, dst_q};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      dst_q   <= dst_d;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (wb_bubble),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  // Never stall while reset is asserted, whatever state is left over.
  assign mem_stall       = rst_n & stall;
  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign mem_err         = err_q;
  assign wb_RegWrite_out = wb_q.reg_write;
  assign wb_MemToReg_out = wb_q.mem_to_reg;
  assign ReadData_out    = wb_q.read_data;
  assign AluResult_out   = wb_q.alu_result;
  assign MuxRegDst_out   = wb_q.reg_dst;

endmodule

// File: tb/tb_mem_access_stage.sv
import mem_pkg::*;

module tb_mem_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite;
  logic        sel_b, ack;
  logic [31:0] AluResult, MuxForwardB, dmem_rdata;
  logic [4:0]  MuxRegDst;

  logic        req_a, we_a, stall_a, err_a, rw_a, m2r_a;
  logic [31:0] addr_a, wd_a, rd_a, alu_a;
  logic [4:0]  dst_a;
  logic        req_b, we_b, stall_b, err_b, rw_b, m2r_b;
  logic [31:0] addr_b, wd_b, rd_b, alu_b;
  logic [4:0]  dst_b;

  // DUT a: default timeout. DUT b: ACK_TIMEOUT = 3, used for the timeout case.
  mem_access_stage u_a (
    .clk(clk), .rst_n(rst_n), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .mem_MemRead(mem_MemRead & ~sel_b), .mem_MemWrite(mem_MemWrite & ~sel_b),
    .AluResult(AluResult), .MuxForwardB(MuxForwardB), .MuxRegDst(MuxRegDst),
    .dmem_req(req_a), .dmem_we(we_a), .dmem_addr(addr_a), .dmem_wdata(wd_a),
    .dmem_rdata(dmem_rdata), .dmem_ack(ack & ~sel_b), .mem_stall(stall_a), .mem_err(err_a),
    .wb_RegWrite_out(rw_a), .wb_MemToReg_out(m2r_a), .ReadData_out(rd_a),
    .AluResult_out(alu_a), .MuxRegDst_out(dst_a));

  mem_access_stage #(.ACK_TIMEOUT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .mem_MemRead(mem_MemRead & sel_b), .mem_MemWrite(mem_MemWrite & sel_b),
    .AluResult(AluResult), .MuxForwardB(MuxForwardB), .MuxRegDst(MuxRegDst),
    .dmem_req(req_b), .dmem_we(we_b), .dmem_addr(addr_b), .dmem_wdata(wd_b),
    .dmem_rdata(dmem_rdata), .dmem_ack(ack & sel_b), .mem_stall(stall_b), .mem_err(err_b),
    .wb_RegWrite_out(rw_b), .wb_MemToReg_out(m2r_b), .ReadData_out(rd_b),
    .AluResult_out(alu_b), .MuxRegDst_out(dst_b));

  logic        o_req, o_we, o_stall, o_err;
  logic [31:0] o_addr, o_wdata;
  memwb_t      o_wb;
  assign o_req   = sel_b ? req_b   : req_a;
  assign o_we    = sel_b ? we_b    : we_a;
  assign o_stall = sel_b ? stall_b : stall_a;
  assign o_err   = sel_b ? err_b   : err_a;
  assign o_addr  = sel_b ? addr_b  : addr_a;
  assign o_wdata = sel_b ? wd_b    : wd_a;
  assign o_wb    = sel_b ? '{rw_b, m2r_b, rd_b, alu_b, dst_b}
                         : '{rw_a, m2r_a, rd_a, alu_a, dst_a};

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: one MEM/WB record per instruction leaving EX/MEM.
  memwb_t sb[$];
  logic   adv = 1'b0;
  always @(posedge clk) adv <= rst_n && !o_stall;

  always @(negedge clk) begin
    memwb_t e;
    if (adv) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wb_rw",   o_wb.reg_write,  e.reg_write);
        chk("wb_m2r",  o_wb.mem_to_reg, e.mem_to_reg);
        chk("wb_rd",   o_wb.read_data,  e.read_data);
        chk("wb_alu",  o_wb.alu_result, e.alu_result);
        chk("wb_dst",  o_wb.reg_dst,    e.reg_dst);
      end
    end
  end

  int   errc_a = 0, errc_b = 0, rises = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (err_a) errc_a++;
    if (err_b) errc_b++;
    if (o_req && !req_prev) rises++;
    req_prev = o_req;
  end

  // Present one EX/MEM instruction (called at a negedge, returns at a negedge
  // with the next slot free). ack_wait < 0 means never acknowledge.
  task automatic run_op(input logic rw, m2r, rd, wr, input logic [31:0] alu, wd,
                        input logic [4:0] dst, input int ack_wait, input logic [31:0] rdat,
                        output int stalls, output int reqs);
    memwb_t e;
    int g;
    wb_RegWrite = rw; wb_MemToReg = m2r; mem_MemRead = rd; mem_MemWrite = wr;
    AluResult = alu; MuxForwardB = wd; MuxRegDst = dst;
    e.reg_write = rw; e.mem_to_reg = m2r; e.alu_result = alu; e.reg_dst = dst;
    if (wr)      e.read_data = 32'h0;
    else if (rd) e.read_data = (ack_wait >= 0) ? rdat : READ_ERR_VAL_DEF;
    else         e.read_data = 32'h0;
    sb.push_back(e);
    stalls = 0; reqs = 0; g = 0;
    #1;
    while (o_stall && g < 40) begin
      stalls++; g++;
      if (stalls > 1) chk("stall_bubble", o_wb.reg_write, 0);
      if (o_req) begin
        reqs++;
        chk("req_we", o_we, wr);
        chk("req_addr", o_addr, alu);
        chk("req_wdata", o_wdata, wd);
      end
      if (o_req && ack_wait >= 0 && reqs == ack_wait + 1) begin
        ack = 1'b1; dmem_rdata = rdat;
      end
      @(negedge clk); #1;
      ack = 1'b0; dmem_rdata = 32'h0;
    end
    if (g >= 40) chk("stall_bound", 1, 0);
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic spur);
    wb_RegWrite = 0; wb_MemToReg = 0; mem_MemRead = 0; mem_MemWrite = 0;
    AluResult = 0; MuxForwardB = 0; MuxRegDst = 0;
    sb.push_back('0);
    ack = spur; dmem_rdata = 32'hBAD0BAD0;
    #1; chk("idle_stall", o_stall, 0);
    @(posedge clk); #1;
    ack = 1'b0; dmem_rdata = 32'h0;
    chk("idle_req", o_req, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stuck");
  end

  initial begin
    int st, rq, r0;
    rst_n = 0; sel_b = 0; ack = 0; dmem_rdata = 0;
    wb_RegWrite = 1; wb_MemToReg = 0; mem_MemRead = 1; mem_MemWrite = 0;
    AluResult = 32'h99; MuxForwardB = 32'h77; MuxRegDst = 5'd3;
    repeat (3) @(negedge clk);
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_req, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_err", o_err, 0);
    chk("rst_wb_rw", o_wb.reg_write, 0);
    chk("rst_wb_alu", o_wb.alu_result, 0);
    rst_n = 1;

    // ALU op, no memory access
    run_op(1, 0, 0, 0, 32'h10, 32'h0, 5'd8, -1, 32'h0, st, rq);
    chk("alu_stalls", st, 0);
    // Load, ack on first request cycle
    run_op(1, 1, 1, 0, 32'h40, 32'h0, 5'd5, 0, 32'hCAFE0001, st, rq);
    chk("ld_stalls", st, 2);
    chk("ld_reqs", rq, 1);
    // Store, four wait cycles before ack
    run_op(0, 0, 0, 1, 32'h44, 32'h12345678, 5'd3, 4, 32'h0, st, rq);
    chk("st_stalls", st, 6);
    chk("st_reqs", rq, 5);
    // Read and write together behave as a write
    run_op(1, 1, 1, 1, 32'h48, 32'hA5A5A5A5, 5'd6, 1, 32'h11111111, st, rq);
    chk("rw_stalls", st, 3);

    // Timeout on the ACK_TIMEOUT = 3 instance
    sel_b = 1;
    run_op(1, 1, 1, 0, 32'h50, 32'h0, 5'd9, -1, 32'h0, st, rq);
    chk("to_stalls", st, 4);
    chk("to_reqs", rq, 3);
    idle_cyc(0);
    idle_cyc(0);
    chk("to_err_pulses", errc_b, 1);
    sel_b = 0;

    // Back-to-back loads plus a spurious ack in IDLE
    r0 = rises;
    run_op(1, 1, 1, 0, 32'h60, 32'h0, 5'd10, 1, 32'h00006060, st, rq);
    run_op(1, 1, 1, 0, 32'h64, 32'h0, 5'd11, 0, 32'h00006464, st, rq);
    chk("b2b_stalls", st, 2);
    idle_cyc(1);
    chk("b2b_req_pulses", rises - r0, 2);
    chk("a_err_pulses", errc_a, 0);

    // Reset while BUSY, then a late ack
    wb_RegWrite = 1; wb_MemToReg = 1; mem_MemRead = 1; mem_MemWrite = 0;
    AluResult = 32'h70; MuxForwardB = 0; MuxRegDst = 5'd12;
    @(negedge clk); @(negedge clk);
    chk("busy_req", o_req, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("rb_req", o_req, 0);
    chk("rb_stall", o_stall, 0);
    chk("rb_wb_rw", o_wb.reg_write, 0);
    chk("rb_wb_rd", o_wb.read_data, 0);
    chk("rb_wb_dst", o_wb.reg_dst, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    idle_cyc(1);
    run_op(1, 0, 0, 0, 32'h123, 32'h0, 5'd13, -1, 32'h0, st, rq);
    chk("post_rst_stalls", st, 0);
    idle_cyc(0);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
